rotor_offset_stage: RTL

//  Enigma rotor offset stage. Accepts one uppercase ASCII letter, adds (encrypt) or subtracts
//  (decrypt) the current rotor position and drives the raw sum as ntcv with direction gr.
//  It consumes the downstream overflow comparator verdict (wrap_in) and applies the +/-26

---
 rtl/rotor_offset_stage_pkg.sv | 20 ++
 rtl/rotor_position_counter.sv | 52 +++++
 rtl/rotor_offset_stage.sv | 111 +++++++++++
 3 files changed

// File: rtl/rotor_offset_stage_pkg.sv
// Shared constants for the Enigma rotor offset stage: ASCII bounds, alphabet size,
// position width and the IDLE/EVAL/OUT state encodings.
package rotor_offset_stage_pkg;

   localparam logic [7:0] ASCII_A   = 8'h41;
   localparam logic [7:0] ASCII_Z   = 8'h5A;
   localparam logic [7:0] ALPHA_LEN = 8'd26;

   localparam int         POS_W     = 5;
   localparam logic [4:0] POS_MAX   = 5'd25;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_EVAL = 2'd1;
   localparam logic [1:0] ST_OUT  = 2'd2;

   function automatic logic is_letter(input logic [7:0] c);
      return (c >= ASCII_A) && (c <= ASCII_Z);
   endfunction

endpackage

// File: rtl/rotor_position_counter.sv
// Rotor position register: load, step with 25->0 wrap, and a one-cycle carry pulse
// when the rotor steps away from its notch position.
module rotor_position_counter
   import rotor_offset_stage_pkg::*;
#(
   parameter int NOTCH_POS = 16,
   parameter int INIT_POS  = 0
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             step,
   input  logic             load,
   input  logic [POS_W-1:0] load_value,
   output logic [POS_W-1:0] pos,
   output logic             carry_out
);

   localparam logic [POS_W-1:0] NOTCH = POS_W'(NOTCH_POS);
   localparam logic [POS_W-1:0] INIT  = POS_W'(INIT_POS);

   logic [POS_W-1:0] pos_q, pos_d;
   logic             carry_q, carry_d;
   logic             load_ok;

   // Out-of-range load values are dropped, letting a coincident step go ahead.
   assign load_ok = load && (load_value <= POS_MAX);

   always_comb begin
      pos_d   = pos_q;
      carry_d = 1'b0;
      if (load_ok) begin
         pos_d = load_value;
      end else if (step) begin
         pos_d   = (pos_q == POS_MAX) ? '0 : pos_q + 5'd1;
         carry_d = (pos_q == NOTCH);
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         pos_q   <= INIT;
         carry_q <= 1'b0;
      end else begin
         pos_q   <= pos_d;
         carry_q <= carry_d;
      end
   end

   assign pos       = pos_q;
   assign carry_out = carry_q;

endmodule

// File: rtl/rotor_offset_stage.sv
// Enigma rotor offset stage: offsets a letter by the rotor position, applies the wrap
// verdict from the external overflow comparator and steps the rotor.
module rotor_offset_stage
   import rotor_offset_stage_pkg::*;
#(
   parameter int NOTCH_POS = 16,
   parameter int INIT_POS  = 0
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [7:0]       in_char,
   input  logic             decrypt,
   input  logic             step_en,
   input  logic             pos_load,
   input  logic [POS_W-1:0] pos_value,
   output logic [7:0]       ntcv,
   output logic             gr,
   input  logic             wrap_in,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [7:0]       out_char,
   output logic [POS_W-1:0] pos,
   output logic             carry_out
);

   logic [1:0] state_q, state_d;
   logic [7:0] ntcv_q, ntcv_d;
   logic       gr_q, gr_d;
   logic [7:0] out_char_q, out_char_d;
   logic       step_q, step_d;
   logic [7:0] pos_ext;

   assign pos_ext = {{(8 - POS_W){1'b0}}, pos};

   always_comb begin
      state_d    = state_q;
      ntcv_d     = ntcv_q;
      gr_d       = gr_q;
      out_char_d = out_char_q;
      step_d     = step_q;
      case (state_q)
         ST_IDLE: begin
            if (in_valid) begin
               if (is_letter(in_char)) begin
                  // Offset uses the pre-step position; the step lands on the EVAL edge.
                  ntcv_d  = decrypt ? (in_char - pos_ext) : (in_char + pos_ext);
                  gr_d    = decrypt;
                  step_d  = step_en;
                  state_d = ST_EVAL;
               end else begin
                  out_char_d = in_char;
                  step_d     = 1'b0;
                  state_d    = ST_OUT;
               end
            end
         end
         ST_EVAL: begin
            if (wrap_in) begin
               out_char_d = gr_q ? (ntcv_q + ALPHA_LEN) : (ntcv_q - ALPHA_LEN);
            end else begin
               out_char_d = ntcv_q;
            end
            state_d = ST_OUT;
         end
         ST_OUT: begin
            if (out_ready) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q    <= ST_IDLE;
         ntcv_q     <= 8'h00;
         gr_q       <= 1'b0;
         out_char_q <= 8'h00;
         step_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         ntcv_q     <= ntcv_d;
         gr_q       <= gr_d;
         out_char_q <= out_char_d;
         step_q     <= step_d;
      end
   end

   rotor_position_counter #(
      .NOTCH_POS (NOTCH_POS),
      .INIT_POS  (INIT_POS)
   ) u_pos (
      .clk        (clk),
      .resetn     (resetn),
      .step       ((state_q == ST_EVAL) && step_q),
      .load       (pos_load),
      .load_value (pos_value),
      .pos        (pos),
      .carry_out  (carry_out)
   );

   assign in_ready  = (state_q == ST_IDLE);
   assign out_valid = (state_q == ST_OUT);
   assign ntcv      = ntcv_q;
   assign gr        = gr_q;
   assign out_char  = out_char_q;

endmodule
